memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, meaning the scalar word and the packed 6x8-bit vector word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the data-memory word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for memAck.
REQ-004 Ports (name  direction  width  meaning):
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
inValid  in  1  execute result valid
inReady  out  1  stage can accept; execute stalls when low
aluResult  in  DATA_WIDTH  execute output; address for memory ops
storeData  in  DATA_WIDTH  execute dataToWrite
memRead, memWrite, regWrite, isScalar  in  1 each  control
destReg  in  5  destination register
flagsIn  in  4  {N,Z,V,C} from execute
memReq  out  1  memory request
memWe  out  1  1 = write
memAddr  out  ADDR_WIDTH  word address
memWdata  out  DATA_WIDTH  store data
memRdata  in  DATA_WIDTH  load data
memAck  in  1  memory completion
wbValid  out  1  writeback output valid
wbReady  in  1  writeback accepts
wbData  out  DATA_WIDTH  load data or ALU result
wbDest  out  5  destination register
wbRegWrite, wbIsScalar  out  1 each  forwarded control
wbFlags  out  4  registered flags
memError  out  1  sticky timeout flag

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS and HOLD.
REQ-006 inReady SHALL be 1 only when the state is IDLE and either wbValid=0 or wbReady=1.
REQ-007 A transfer SHALL occur on a rising edge with inValid=1 and inReady=1; all inputs SHALL be captured on that edge.
REQ-008 On a non-memory transfer, the stage SHALL stay in IDLE, set wbValid=1 on the next edge, and drive wbData=aluResult, wbDest, wbRegWrite, wbIsScalar and wbFlags from the captured values (1-cycle latency).
REQ-009 On a memory transfer, the stage SHALL go to ACCESS and assert memReq=1 from the following cycle.
  - memAddr=aluResult[ADDR_WIDTH-1:0]; upper address bits are ignored.
  - memWe=memWrite.
  - memWdata=storeData.
REQ-010 If memRead and memWrite are both 1, the write SHALL take precedence and the operation SHALL be treated as a store.
REQ-011 In ACCESS, memReq, memWe, memAddr and memWdata SHALL hold stable until memAck=1 is sampled.
REQ-012 memAck SHALL be ignored while memReq=0.
REQ-013 On the edge sampling memAck=1 in ACCESS, the stage SHALL:
  - deassert memReq;
  - set wbValid=1;
  - drive wbData=memRdata for a load, or aluResult for a store;
  - force wbRegWrite=0 for a store;
  - return to IDLE.
REQ-014 A 4-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with memAck=0.
REQ-015 When the counter reaches TIMEOUT with memAck=0, the stage SHALL:
  - deassert memReq;
  - set memError=1 (sticky until reset);
  - set wbValid=1 with wbData=0 for a load, or aluResult for a store;
  - return to IDLE.
REQ-016 HOLD SHALL be entered instead of IDLE when a memory access completes while wbValid=1 and wbReady=0.
  - HOLD buffers the result and exits to IDLE when the pending output is consumed.
  - In HOLD, inReady=0 and memReq=0.
REQ-017 wbValid and all wb* outputs SHALL remain stable while wbValid=1 and wbReady=0.
REQ-018 wbValid SHALL clear on an edge with wbReady=1 unless a new result is produced on that same edge, in which case it stays 1 with the new values.
REQ-019 Back-to-back non-memory transfers SHALL sustain one result per cycle when wbReady=1.
REQ-020 All outputs except inReady SHALL be registered.

Reset
REQ-021 rst_n=0 SHALL asynchronously force:
  - state IDLE and counter 0;
  - memReq, memWe, wbValid, wbRegWrite, wbIsScalar and memError to 0;
  - memAddr, memWdata, wbData, wbDest and wbFlags to 0.
REQ-022 Reset asserted mid-access SHALL abandon the request immediately (memReq=0 asynchronously) with no writeback.
REQ-023 After rst_n deasserts, inReady SHALL be 1 in the first cycle.

Verification
REQ-024 ALU op: aluResult=0x0000_0000_002A, destReg=3, regWrite=1, wbReady=1 -> next cycle wbValid=1, wbData=0x2A, wbDest=3, wbRegWrite=1.
REQ-025 Load: aluResult=0x10, memRead=1; memAck after 3 cycles with memRdata=0x0102_0304_0506 -> memAddr=0x0010 and memReq=1 for 3 cycles; inReady=0 throughout; wbData=0x0102_0304_0506.
REQ-026 Store with memRead=memWrite=1, storeData=0xFFEE_DDCC_BBAA -> memWe=1, memWdata=0xFFEE_DDCC_BBAA, wbRegWrite=0.
REQ-027 Load with memAck held 0 -> memReq drops after 15 wait cycles, memError=1, wbData=0; memError stays 1 across later ops.
REQ-028 Backpressure: wbReady=0 for 4 cycles during back-to-back ALU ops -> wb* outputs stable, inReady=0; resumes one result per cycle when wbReady=1.
REQ-029 rst_n pulsed low during ACCESS -> memReq=0 immediately, wbValid=0, inReady=1 after release.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// Bundles the execute-side input, data-memory port and writeback output of the
// memory access stage; "slave" is the stage itself, "master" is its environment.
interface memory_access_stage_if #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 16
);
  logic                  inValid;
  logic                  inReady;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [DATA_WIDTH-1:0] storeData;
  logic                  memRead;
  logic                  memWrite;
  logic                  regWrite;
  logic                  isScalar;
  logic [4:0]            destReg;
  logic [3:0]            flagsIn;

  logic                  memReq;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  memAck;

  logic                  wbValid;
  logic                  wbReady;
  logic [DATA_WIDTH-1:0] wbData;
  logic [4:0]            wbDest;
  logic                  wbRegWrite;
  logic                  wbIsScalar;
  logic [3:0]            wbFlags;
  logic                  memError;

  modport slave (
    input  inValid, aluResult, storeData, memRead, memWrite, regWrite, isScalar,
           destReg, flagsIn, memRdata, memAck, wbReady,
    output inReady, memReq, memWe, memAddr, memWdata,
           wbValid, wbData, wbDest, wbRegWrite, wbIsScalar, wbFlags, memError
  );

  modport master (
    output inValid, aluResult, storeData, memRead, memWrite, regWrite, isScalar,
           destReg, flagsIn, memRdata, memAck, wbReady,
    input  inReady, memReq, memWe, memAddr, memWdata,
           wbValid, wbData, wbDest, wbRegWrite, wbIsScalar, wbFlags, memError
  );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: forwards ALU results in one cycle, or performs one
// data-memory load/store with ack handshake and wait-cycle timeout.
module memory_access_stage #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  memory_access_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic [3:0] LP_LAST_WAIT = 4'(TIMEOUT - 1);

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [4:0]            r_wb_dest;
  logic                  r_wb_reg_write;
  logic                  r_wb_is_scalar;
  logic [3:0]            r_wb_flags;
  logic                  r_mem_error;

  logic                  r_op_store;
  logic [DATA_WIDTH-1:0] r_op_alu;
  logic [4:0]            r_op_dest;
  logic                  r_op_reg_write;
  logic                  r_op_is_scalar;
  logic [3:0]            r_op_flags;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_reg_write;

  logic                  w_in_ready;
  logic                  w_fire;
  logic                  w_is_mem;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_wb_blocked;
  logic [DATA_WIDTH-1:0] w_res_data;
  logic                  w_res_reg_write;

  assign w_in_ready   = (r_state == S_IDLE) && (!r_wb_valid || bus.wbReady);
  assign w_fire       = bus.inValid && w_in_ready;
  assign w_is_mem     = bus.memRead || bus.memWrite;
  assign w_timeout    = (r_state == S_ACCESS) && !bus.memAck && (r_wait_cnt == LP_LAST_WAIT);
  assign w_done       = (r_state == S_ACCESS) && (bus.memAck || w_timeout);
  assign w_wb_blocked = r_wb_valid && !bus.wbReady;

  // A timed-out load writes back zero; a store always returns its address operand.
  assign w_res_data      = r_op_store ? r_op_alu : (bus.memAck ? bus.memRdata : '0);
  assign w_res_reg_write = r_op_reg_write && !r_op_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_wait_cnt       <= '0;
      r_mem_req        <= 1'b0;
      r_mem_we         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_data        <= '0;
      r_wb_dest        <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_is_scalar   <= 1'b0;
      r_wb_flags       <= '0;
      r_mem_error      <= 1'b0;
      r_op_store       <= 1'b0;
      r_op_alu         <= '0;
      r_op_dest        <= '0;
      r_op_reg_write   <= 1'b0;
      r_op_is_scalar   <= 1'b0;
      r_op_flags       <= '0;
      r_hold_data      <= '0;
      r_hold_reg_write <= 1'b0;
    end else begin
      if (r_wb_valid && bus.wbReady) begin
        r_wb_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_op_store     <= bus.memWrite;
            r_op_alu       <= bus.aluResult;
            r_op_dest      <= bus.destReg;
            r_op_reg_write <= bus.regWrite;
            r_op_is_scalar <= bus.isScalar;
            r_op_flags     <= bus.flagsIn;
            if (w_is_mem) begin
              r_state     <= S_ACCESS;
              r_wait_cnt  <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.memWrite;
              r_mem_addr  <= bus.aluResult[ADDR_WIDTH-1:0];
              r_mem_wdata <= bus.storeData;
            end else begin
              r_wb_valid     <= 1'b1;
              r_wb_data      <= bus.aluResult;
              r_wb_dest      <= bus.destReg;
              r_wb_reg_write <= bus.regWrite;
              r_wb_is_scalar <= bus.isScalar;
              r_wb_flags     <= bus.flagsIn;
            end
          end
        end

        S_ACCESS: begin
          if (!bus.memAck) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (w_timeout) begin
              r_mem_error <= 1'b1;
            end
            // Park the result if the previous writeback has not been taken yet.
            if (w_wb_blocked) begin
              r_hold_data      <= w_res_data;
              r_hold_reg_write <= w_res_reg_write;
              r_state          <= S_HOLD;
            end else begin
              r_wb_valid     <= 1'b1;
              r_wb_data      <= w_res_data;
              r_wb_dest      <= r_op_dest;
              r_wb_reg_write <= w_res_reg_write;
              r_wb_is_scalar <= r_op_is_scalar;
              r_wb_flags     <= r_op_flags;
              r_state        <= S_IDLE;
            end
          end
        end

        S_HOLD: begin
          if (bus.wbReady) begin
            r_wb_valid     <= 1'b1;
            r_wb_data      <= r_hold_data;
            r_wb_dest      <= r_op_dest;
            r_wb_reg_write <= r_hold_reg_write;
            r_wb_is_scalar <= r_op_is_scalar;
            r_wb_flags     <= r_op_flags;
            r_state        <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inReady    = w_in_ready;
  assign bus.memReq     = r_mem_req;
  assign bus.memWe      = r_mem_we;
  assign bus.memAddr    = r_mem_addr;
  assign bus.memWdata   = r_mem_wdata;
  assign bus.wbValid    = r_wb_valid;
  assign bus.wbData     = r_wb_data;
  assign bus.wbDest     = r_wb_dest;
  assign bus.wbRegWrite = r_wb_reg_write;
  assign bus.wbIsScalar = r_wb_is_scalar;
  assign bus.wbFlags    = r_wb_flags;
  assign bus.memError   = r_mem_error;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench: stimulus pushes expected memory requests and writebacks,
// a memory responder and a writeback monitor pop and compare independently.
module tb_memory_access_stage;
  localparam int DW = 48;
  localparam int AW = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_access_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_access_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] alu, sd, rdata;
    logic rd, wr, rw, sc;
    logic [4:0] dest;
    logic [3:0] flags;
    int delay;  // memory ack on this request cycle; 0 = never ack
  } op_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0] dest;
    logic rw, sc;
    logic [3:0] flags;
    logic err;
  } wb_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic we;
    logic [DW-1:0] wdata, rdata;
    int delay;
  } mem_t;

  wb_t  wb_q[$];
  mem_t mem_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic err_model = 1'b0;
  bit   force_wb = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic op_t alu_op(input logic [DW-1:0] a, input logic [4:0] d);
    op_t o;
    o.alu = a; o.sd = '0; o.rdata = '0; o.rd = 0; o.wr = 0; o.rw = 1; o.sc = 1;
    o.dest = d; o.flags = 4'h5; o.delay = 1;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    k = int'($urandom_range(0, 9));
    o.alu = rand48(); o.sd = rand48(); o.rdata = rand48();
    o.rw = 1'($urandom_range(0, 1)); o.sc = 1'($urandom_range(0, 1));
    o.dest = 5'($urandom_range(0, 31)); o.flags = 4'($urandom_range(0, 15));
    o.delay = int'($urandom_range(1, 5));
    o.rd = 0; o.wr = 0;
    if (k >= 4 && k <= 6) o.rd = 1;
    else if (k == 7 || k == 8) begin o.wr = 1; o.rd = 1'($urandom_range(0, 1)); end
    else if (k == 9) begin o.delay = 0; o.wr = 1'($urandom_range(0, 1)); o.rd = !o.wr; end
    return o;
  endfunction

  // Called on a negedge; returns on the negedge after the op was accepted.
  task automatic send(input op_t op, output int waits);
    wb_t  w;
    mem_t m;
    bit   is_mem;
    waits = 0;
    bus.aluResult = op.alu; bus.storeData = op.sd; bus.memRead = op.rd; bus.memWrite = op.wr;
    bus.regWrite = op.rw; bus.isScalar = op.sc; bus.destReg = op.dest; bus.flagsIn = op.flags;
    bus.inValid = 1'b1;
    #1;
    while (!bus.inReady) begin
      @(negedge clk); #1;
      waits++;
      if (waits > 200) begin
        check("accept_bound", 64'(waits), 64'd200);
        bus.inValid = 1'b0;
        return;
      end
    end
    is_mem = op.rd || op.wr;
    if (is_mem) begin
      m.addr = op.alu[AW-1:0]; m.we = op.wr; m.wdata = op.sd; m.rdata = op.rdata; m.delay = op.delay;
      mem_q.push_back(m);
      if (op.delay == 0) err_model = 1'b1;
    end
    if (is_mem && !op.wr) w.data = (op.delay == 0) ? '0 : op.rdata;
    else                  w.data = op.alu;
    w.rw = op.wr ? 1'b0 : op.rw;
    w.dest = op.dest; w.sc = op.sc; w.flags = op.flags; w.err = err_model;
    wb_q.push_back(w);
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0 || bus.memReq) && c < 600) begin
      @(negedge clk);
      c++;
    end
    check("drain_bound", 64'(c < 600), 64'd1);
  endtask

  // Random writeback backpressure unless the stimulus has taken control of it.
  initial forever begin
    @(negedge clk);
    if (!force_wb) bus.wbReady = ($urandom_range(0, 3) != 0);
  end

  // Memory responder: checks each request against the queue and acks on schedule.
  initial begin
    mem_t cur;
    int   cnt;
    bit   active;
    cnt = 0; active = 0;
    cur.addr = '0; cur.we = 0; cur.wdata = '0; cur.rdata = '0; cur.delay = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; cnt = 0; bus.memAck = 1'b0;
        continue;
      end
      if (bus.memReq) begin
        if (!active) begin
          active = 1; cnt = 0;
          if (mem_q.size() == 0) check("unexpected_mem_req", 64'd1, 64'd0);
          else cur = mem_q.pop_front();
          check("mem_addr", 64'(bus.memAddr), 64'(cur.addr));
          check("mem_we", 64'(bus.memWe), 64'(cur.we));
          check("mem_wdata", 64'(bus.memWdata), 64'(cur.wdata));
        end else begin
          check("mem_addr_stable", 64'(bus.memAddr), 64'(cur.addr));
          check("mem_we_stable", 64'(bus.memWe), 64'(cur.we));
          check("mem_wdata_stable", 64'(bus.memWdata), 64'(cur.wdata));
        end
        cnt++;
        check("in_ready_during_access", 64'(bus.inReady), 64'd0);
        if (cur.delay != 0 && cnt == cur.delay) begin
          bus.memAck = 1'b1; bus.memRdata = cur.rdata;
        end else begin
          bus.memAck = 1'b0; bus.memRdata = rand48();
        end
      end else begin
        if (active) begin
          check("mem_req_cycles", 64'(cnt), 64'((cur.delay == 0) ? TO : cur.delay));
          active = 0;
        end
        bus.memAck = 1'($urandom_range(0, 1));
        bus.memRdata = rand48();
      end
    end
  end

  // Writeback monitor: pops on each accepted result, checks stability under stall.
  initial begin
    wb_t prev;
    wb_t e;
    bit  stall;
    stall = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        stall = 0;
        continue;
      end
      if (stall) begin
        check("wb_valid_stable", 64'(bus.wbValid), 64'd1);
        check("wb_data_stable", 64'(bus.wbData), 64'(prev.data));
        check("wb_dest_stable", 64'(bus.wbDest), 64'(prev.dest));
        check("wb_flags_stable", 64'(bus.wbFlags), 64'(prev.flags));
      end
      if (bus.wbValid && bus.wbReady) begin
        stall = 0;
        if (wb_q.size() == 0) begin
          check("unexpected_wb", 64'd1, 64'd0);
        end else begin
          e = wb_q.pop_front();
          $display("[TB] wb data=0x%012h dest=%0d rw=%0b err=%0b", bus.wbData, bus.wbDest,
                   bus.wbRegWrite, bus.memError);
          check("wb_data", 64'(bus.wbData), 64'(e.data));
          check("wb_dest", 64'(bus.wbDest), 64'(e.dest));
          check("wb_reg_write", 64'(bus.wbRegWrite), 64'(e.rw));
          check("wb_is_scalar", 64'(bus.wbIsScalar), 64'(e.sc));
          check("wb_flags", 64'(bus.wbFlags), 64'(e.flags));
          check("mem_error", 64'(bus.memError), 64'(e.err));
        end
      end else if (bus.wbValid) begin
        stall = 1;
        prev.data = bus.wbData; prev.dest = bus.wbDest; prev.flags = bus.wbFlags;
        prev.rw = bus.wbRegWrite; prev.sc = bus.wbIsScalar; prev.err = bus.memError;
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    op_t op;
    int  w;
    bus.inValid = 0; bus.aluResult = '0; bus.storeData = '0; bus.memRead = 0; bus.memWrite = 0;
    bus.regWrite = 0; bus.isScalar = 0; bus.destReg = '0; bus.flagsIn = '0;
    bus.memRdata = '0; bus.memAck = 0; bus.wbReady = 1;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(bus.memReq), 64'd0);
    check("rst_wb_valid", 64'(bus.wbValid), 64'd0);
    check("rst_mem_error", 64'(bus.memError), 64'd0);
    check("rst_wb_data", 64'(bus.wbData), 64'd0);
    check("rst_mem_addr", 64'(bus.memAddr), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(bus.inReady), 64'd1);
    @(negedge clk);

    // ALU op with one-cycle latency
    send(alu_op(48'h0000_0000_002A, 5'd3), w);
    #1;
    check("alu_latency_valid", 64'(bus.wbValid), 64'd1);
    check("alu_latency_data", 64'(bus.wbData), 64'h2A);
    @(negedge clk);

    // Load acked on the third request cycle
    op = alu_op(48'h10, 5'd7); op.rd = 1; op.delay = 3; op.rdata = 48'h0102_0304_0506;
    send(op, w);
    wait_idle();

    // Both read and write set: behaves as a store
    op = alu_op(48'h1234, 5'd9); op.rd = 1; op.wr = 1; op.delay = 2; op.sd = 48'hFFEE_DDCC_BBAA;
    send(op, w);
    wait_idle();

    // Load with no ack: times out, error becomes sticky
    op = alu_op(48'h20, 5'd4); op.rd = 1; op.delay = 0;
    send(op, w);
    wait_idle();
    send(alu_op(48'h55, 5'd1), w);
    wait_idle();

    // Backpressure during back-to-back ALU ops
    bus.wbReady = 1'b0;
    send(alu_op(48'hA1, 5'd10), w);
    bus.aluResult = 48'hB2; bus.inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("in_ready_backpressure", 64'(bus.inReady), 64'd0);
      @(negedge clk);
    end
    bus.wbReady = 1'b1;
    send(alu_op(48'hB2, 5'd11), w);
    check("throughput_b", 64'(w), 64'd0);
    send(alu_op(48'hC3, 5'd12), w);
    check("throughput_c", 64'(w), 64'd0);
    send(alu_op(48'hD4, 5'd13), w);
    check("throughput_d", 64'(w), 64'd0);
    wait_idle();

    // Randomized mix with random backpressure
    #1 force_wb = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 250; n++) begin
      send(rand_op(), w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_idle();

    // Reset asserted in the middle of an access
    #1 force_wb = 1'b1;
    bus.wbReady = 1'b1;
    @(negedge clk);
    op = alu_op(48'h40, 5'd2); op.rd = 1; op.delay = 0;
    send(op, w);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_mem_req", 64'(bus.memReq), 64'd0);
    check("reset_mid_wb_valid", 64'(bus.wbValid), 64'd0);
    check("reset_mid_mem_error", 64'(bus.memError), 64'd0);
    wb_q.delete();
    mem_q.delete();
    err_model = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("in_ready_after_release", 64'(bus.inReady), 64'd1);
    @(negedge clk);
    send(alu_op(48'h77, 5'd6), w);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
